sdram_read_arbiter: RTL
=======================

// Module: sdram_read_arbiter
// PURPOSE
//  Shares the single SDRAM read port between two requesters.
//  Requester 0 is the VGA display fetch: high priority, latency-critical.
//  Requester 1 is the image resize/averaging engine: low priority, bulk reads.
//  Issues one-cycle read strobes with addresses, tags each in-flight read with its owner,
//  and routes the returned pixel back to that owner with a valid pulse.
//  A starvation limiter guarantees the resize engine forward progress.
// PARAMETERS
//  ADDR_W      23  SDRAM word address width
//  DATA_W      8   pixel/data width
//  RD_LAT      3   cycles from mem_start to valid mem_data (fixed, >=1)
//  STARVE_MAX  8   max consecutive display grants while resize is pending (>=1)
// PORTS
//  clk            in   1       system clock; single clock domain
//  rst            in   1       synchronous, active-high reset
//  disp_req       in   1       display requests a read (level)
//  disp_addr      in   ADDR_W  display read address, valid while disp_req=1
//  disp_gnt       out  1       display request accepted this cycle (combinational)
//  disp_rvalid    out  1       rd_data belongs to display (1-cycle pulse)
//  resize_req     in   1       resize engine requests a read (level)
//  resize_addr    in   ADDR_W  resize read address, valid while resize_req=1
//  resize_gnt     out  1       resize request accepted this cycle (combinational)
//  resize_rvalid  out  1       rd_data belongs to resize engine (1-cycle pulse)
//  rd_data        out  DATA_W  returned read data, registered
//  mem_rdy        in   1       SDRAM controller can accept a read this cycle
//  mem_start      out  1       read strobe to SDRAM controller (1-cycle pulse)
//  mem_addr       out  ADDR_W  read address, valid when mem_start=1
//  mem_data       in   DATA_W  SDRAM read data, valid RD_LAT cycles after mem_start
// BEHAVIOUR
//  Reset: mem_start, mem_addr, rd_data, disp_rvalid, resize_rvalid = 0.
//   Starvation counter and owner-tag pipeline are cleared.
//   Reads in flight at reset are dropped: no rvalid is ever produced for them.
//   disp_gnt and resize_gnt are 0 while rst=1.
//  Arbitration in cycle N, only when mem_rdy=1; at most one grant per cycle:
//   - Default: disp_req wins. resize is granted only if disp_req=0.
//   - Exception: starve_cnt==STARVE_MAX and resize_req=1 -> resize wins even if disp_req=1.
//   - mem_rdy=0: no grants; requests must be held (req is level, not consumed).
//  A request is consumed on the clk edge where req&gnt=1.
//   The requester may present its next address in cycle N+1.
//  Issue timing:
//   - Cycle N+1: mem_start=1 and mem_addr = granted address (registered).
//   - Back-to-back grants produce mem_start on consecutive cycles.
//  Return timing:
//   - Owner tag shifts through a (RD_LAT+1)-deep pipeline.
//   - mem_data is sampled at cycle N+1+RD_LAT.
//   - rd_data and the owner's rvalid are asserted at N+2+RD_LAT.
//   - Fixed total latency: RD_LAT+2 cycles from grant to rvalid.
//   - disp_rvalid and resize_rvalid are never both 1.
//   - rd_data holds its last value when no rvalid is asserted.
//  Starvation counter (width $clog2(STARVE_MAX+1), saturates at STARVE_MAX):
//   - +1 on each display grant while resize_req=1.
//   - Cleared on a resize grant, or any cycle with resize_req=0.
//   - Unchanged when no grant occurs (e.g. mem_rdy=0).
//  No FSM beyond the counter; all returns are in order, with no reordering.
// TESTING
//  1. Only resize_req=1, addr 0..4, mem_rdy=1, RD_LAT=3 -> resize_gnt 5 consecutive cycles;
//     mem_start cycles 1-5 with addr 0..4; resize_rvalid cycles 5-9 with matching data.
//  2. Both req high for 20 cycles, STARVE_MAX=8 -> pattern 8 disp grants, 1 resize grant,
//     repeating; resize gets exactly 2 of the first 18 grants.
//  3. disp_req=1 with mem_rdy=0 for 4 cycles -> no gnt, no mem_start, counter unchanged.
//     mem_rdy->1: grant next cycle, same addr.
//  4. Interleaved grants D,R,D -> disp_rvalid, resize_rvalid, disp_rvalid in that order,
//     each exactly RD_LAT+2 cycles after its grant, data matching the issued address.
//  5. rst=1 for 1 cycle while 3 reads are in flight -> all outputs 0 next cycle;
//     no rvalid for the dropped reads; a new grant proceeds normally.
//  6. resize_req drops after 5 display grants -> counter clears.
//     resize_req re-raised -> 8 more display grants needed before resize preempts.

Source files
------------

// File: rtl/sdram_read_arbiter_if.sv
// Read-port bundle between the two requesters, the arbiter and the SDRAM controller.
// The slave modport is the arbiter's view. The master modport is the
// requester/memory side that drives requests and read data.
interface sdram_read_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic              resize_req;
    logic [ADDR_W-1:0] resize_addr;
    logic              resize_gnt;
    logic              resize_rvalid;
    logic [DATA_W-1:0] rd_data;
    logic              mem_rdy;
    logic              mem_start;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  disp_req, disp_addr, resize_req, resize_addr, mem_rdy, mem_data,
        output disp_gnt, disp_rvalid, resize_gnt, resize_rvalid, rd_data,
               mem_start, mem_addr
    );

    modport master (
        output disp_req, disp_addr, resize_req, resize_addr, mem_rdy, mem_data,
        input  disp_gnt, disp_rvalid, resize_gnt, resize_rvalid, rd_data,
               mem_start, mem_addr
    );
endinterface

// File: rtl/sdram_read_arbiter.sv
// Two-requester SDRAM read arbiter: display fetch has priority, resize engine
// is protected from starvation. Every issued read carries an owner tag down a
// fixed-latency pipeline, so returned data is routed in order to its owner.
module sdram_read_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 3,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_read_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  starve_cnt;
    logic              starved;
    logic              disp_win;
    logic              resize_win;
    logic              any_gnt;

    logic              mem_start_p0;
    logic [ADDR_W-1:0] mem_addr_p0;
    logic [RD_LAT:0]   tag_vld_p0;
    logic [RD_LAT:0]   tag_own_p0;

    logic              disp_rvalid_p1;
    logic              resize_rvalid_p1;
    logic [DATA_W-1:0] rd_data_p1;

    // Counter stops at STARVE_MAX; the preempt decision only needs equality.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_W'(STARVE_MAX))
            return v;
        return v + CNT_W'(1);
    endfunction

    // Grant decision: display by default, resize when idle or starved.
    always_comb begin
        starved    = (starve_cnt == CNT_W'(STARVE_MAX));
        resize_win = !rst && bus.mem_rdy && bus.resize_req &&
                     (!bus.disp_req || starved);
        disp_win   = !rst && bus.mem_rdy && bus.disp_req && !resize_win;
        any_gnt    = disp_win || resize_win;
    end

    assign bus.disp_gnt   = disp_win;
    assign bus.resize_gnt = resize_win;

    // Starvation counter: counts display wins that bypassed a waiting resize.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (!bus.resize_req || resize_win)
            starve_cnt <= '0;
        else if (disp_win)
            starve_cnt <= sat_inc(starve_cnt);
    end

    // Stage p0: issue strobe/address and push the owner tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_start_p0 <= 1'b0;
            mem_addr_p0  <= '0;
            tag_vld_p0   <= '0;
            tag_own_p0   <= '0;
        end else begin
            mem_start_p0 <= any_gnt;
            if (any_gnt)
                mem_addr_p0 <= resize_win ? bus.resize_addr : bus.disp_addr;
            tag_vld_p0 <= {tag_vld_p0[RD_LAT-1:0], any_gnt};
            tag_own_p0 <= {tag_own_p0[RD_LAT-1:0], resize_win};
        end
    end

    // Stage p1: capture returning data and pulse the owner's valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_rvalid_p1   <= 1'b0;
            resize_rvalid_p1 <= 1'b0;
            rd_data_p1       <= '0;
        end else begin
            disp_rvalid_p1   <= tag_vld_p0[RD_LAT] && !tag_own_p0[RD_LAT];
            resize_rvalid_p1 <= tag_vld_p0[RD_LAT] &&  tag_own_p0[RD_LAT];
            if (tag_vld_p0[RD_LAT])
                rd_data_p1 <= bus.mem_data;
        end
    end

    assign bus.mem_start     = mem_start_p0;
    assign bus.mem_addr      = mem_addr_p0;
    assign bus.disp_rvalid   = disp_rvalid_p1;
    assign bus.resize_rvalid = resize_rvalid_p1;
    assign bus.rd_data       = rd_data_p1;
endmodule
